lr_entry_to_number: RTL
=======================

// Module: lr_entry_to_number
// PURPOSE
//  Keypad-side digit-entry packer; the inverse path of the number-to-L/R display splitter.
//  Collects up to two decimal key codes into an L/R digit pair. On ENTER, forms the 7-bit
//  number code (00..99, or 110 = blank) with a multi-cycle shift-add and offers it on a
//  valid/ready output. Drives live dispL/dispR in the same L/R digit-code space for the 7-seg path.
// PARAMETERS
//  NUM_W        7    width of out_number
//  CODE_W       4    width of key and display digit codes
//  BLANK_CODE   11   digit code that renders a blank segment
//  BLANK_NUMBER 110  number code meaning "both digits blank"
// PORTS
//  clk_50MHz   in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high; clears all state
//  in_valid    in   1       key code offered this cycle
//  in_ready    out  1       key accepted when in_valid & in_ready
//  in_code     in   CODE_W  0..9 digit, 12 CLR, 13 ENT, 14 BSP; 10/11/15 consumed, no effect
//  out_valid   out  1       out_number valid; held until out_ready
//  out_ready   in   1       downstream accepts out_number
//  out_number  out  NUM_W   packed number code (0..99 or BLANK_NUMBER)
//  dispL       out  CODE_W  current tens digit code (BLANK_CODE when empty)
//  dispR       out  CODE_W  current ones digit code (BLANK_CODE when empty)
// BEHAVIOUR
//  - One clock (clk_50MHz); reset async, active-high. All outputs registered except in_ready.
//  - Reset values: state EMPTY, out_valid 0, out_number 0, dispL=dispR=BLANK_CODE, acc 0.
//    in_ready = 1 in EMPTY/ONE/TWO, 0 in MUL/EMIT (decoded from state).
//  - States: EMPTY, ONE, TWO, MUL (3 sub-cycles), EMIT. Only accepted keys change state.
//  - EMPTY: digit d -> R=d, L=blank, ONE. ENT -> out_number=BLANK_NUMBER, EMIT. CLR/BSP -> stay.
//  - ONE (L blank, R=d): digit e -> L=d, R=e, TWO (entry shifts in from the right).
//    BSP/CLR -> EMPTY. ENT -> MUL with tens = 0.
//  - TWO: digit -> ignored, no change (entry full). BSP -> R=L, L=blank, ONE. CLR -> EMPTY.
//    ENT -> MUL.
//  - MUL (exactly 3 cycles): acc=tens<<3; acc+=tens<<1; acc+=ones. tens = L, or 0 when L is blank.
//    Max 99; acc is 7 bits; no overflow possible. Then out_number=acc, out_valid=1, EMIT.
//  - Latency: ENT accepted at edge N from ONE/TWO -> out_valid=1 after edge N+4.
//    ENT from EMPTY -> out_valid=1 after edge N+1.
//  - EMIT: out_number and out_valid stable while out_ready=0. in_ready=0; keys are not accepted.
//    On out_valid & out_ready: out_valid 0, dispL=dispR=blank, EMPTY. in_ready=1 next cycle.
//  - dispL/dispR follow the entry and hold through MUL/EMIT. They blank on the output handshake.
//  - Reset mid-MUL/EMIT: pending result discarded, out_valid drops asynchronously, no late emission.
//  - Simultaneous events: none. Only one key per cycle, and no key is accepted while out_valid is high.
// STRUCTURE
//  - Shared header digit_codes.vh: KEY_CLR=12, KEY_ENT=13, KEY_BSP=14, BLANK_CODE=11,
//    BLANK_NUMBER=110, DIGIT_MAX=9, state encodings. The display splitter uses the same constants.
//  - Sub-module lr_mul10_add: start/done shift-add unit. Inputs tens, ones; output 7-bit sum.
//    Fixed 3 cycles. The top FSM sequences it.
// TESTING
//  1. keys 4,2,ENT, out_ready=1 -> disp 11/4 then 4/2; out_number=42 at ENT+4; disp 11/11 after.
//  2. keys 7,ENT -> out_number=7, disp 11/7 held until handshake.
//  3. ENT in EMPTY -> out_number=110, out_valid at ENT+1; then 0,ENT -> out_number=0 (not 110).
//  4. 9,9,5,ENT -> 5 ignored, 99; 3,8,BSP -> disp 11/3, ENT -> 3; 6,CLR,ENT -> 110.
//  5. out_ready=0 for 10 cycles in EMIT with in_valid=1 -> out_number stable, in_ready=0, disp unchanged.
//  6. reset pulse at MUL cycle 2 -> out_valid stays 0, disp 11/11, in_ready=1 after release.

Source files
------------

// File: rtl/lr_entry_to_number_pkg.sv
// Shared keypad/display code constants and state types for the L/R digit-entry path.
package lr_entry_to_number_pkg;

  localparam logic [3:0] KEY_CLR   = 4'd12;
  localparam logic [3:0] KEY_ENT   = 4'd13;
  localparam logic [3:0] KEY_BSP   = 4'd14;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam int unsigned BLANK_CODE_DEF   = 11;
  localparam int unsigned BLANK_NUMBER_DEF = 110;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO,
    ST_MUL,
    ST_EMIT
  } entry_state_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_SHL3,
    MS_SHL1,
    MS_ONES
  } mul_step_t;

endpackage

// File: rtl/lr_mul10_add.sv
// Fixed three-cycle shift-add unit: o_sum = tens*10 + ones, o_done pulses one cycle after the last step.
module lr_mul10_add
  import lr_entry_to_number_pkg::*;
#(
  parameter int unsigned NUM_W  = 7,
  parameter int unsigned CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CODE_W-1:0] i_tens,
  input  logic [CODE_W-1:0] i_ones,
  output logic              o_done,
  output logic [NUM_W-1:0]  o_sum
);

  mul_step_t        r_step;
  mul_step_t        w_step_nxt;
  logic [NUM_W-1:0] r_acc;
  logic [NUM_W-1:0] r_tens;
  logic [NUM_W-1:0] r_ones;
  logic             r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step <= MS_IDLE;
    else     r_step <= w_step_nxt;
  end

  always_comb begin
    w_step_nxt = r_step;
    case (r_step)
      MS_IDLE: if (i_start) w_step_nxt = MS_SHL3;
      MS_SHL3: w_step_nxt = MS_SHL1;
      MS_SHL1: w_step_nxt = MS_ONES;
      MS_ONES: w_step_nxt = MS_IDLE;
      default: w_step_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_tens <= '0;
      r_ones <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_step)
        MS_IDLE: begin
          if (i_start) begin
            r_tens <= NUM_W'(i_tens);
            r_ones <= NUM_W'(i_ones);
            r_acc  <= '0;
          end
        end
        MS_SHL3: r_acc <= r_tens << 3;
        MS_SHL1: r_acc <= r_acc + (r_tens << 1);
        MS_ONES: begin
          r_acc  <= r_acc + r_ones;
          r_done <= 1'b1;
        end
        default: r_acc <= r_acc;
      endcase
    end
  end

  assign o_done = r_done;
  assign o_sum  = r_acc;

endmodule

// File: rtl/lr_entry_to_number.sv
// Keypad digit-entry packer: collects up to two digits as an L/R pair and emits the packed number on ENTER.
module lr_entry_to_number
  import lr_entry_to_number_pkg::*;
#(
  parameter int unsigned NUM_W        = 7,
  parameter int unsigned CODE_W       = 4,
  parameter int unsigned BLANK_CODE   = BLANK_CODE_DEF,
  parameter int unsigned BLANK_NUMBER = BLANK_NUMBER_DEF
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_W-1:0]  out_number,
  output logic [CODE_W-1:0] dispL,
  output logic [CODE_W-1:0] dispR
);

  localparam logic [CODE_W-1:0] LP_BLANK  = CODE_W'(BLANK_CODE);
  localparam logic [NUM_W-1:0]  LP_BLANKN = NUM_W'(BLANK_NUMBER);

  entry_state_t      r_state;
  entry_state_t      w_state_nxt;
  logic [CODE_W-1:0] r_disp_l;
  logic [CODE_W-1:0] r_disp_r;
  logic              r_out_valid;
  logic [NUM_W-1:0]  r_out_number;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_digit;
  logic              w_key_clr;
  logic              w_key_ent;
  logic              w_key_bsp;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [NUM_W-1:0]  w_mul_sum;
  logic [CODE_W-1:0] w_tens;

  assign w_accept    = in_valid & w_in_ready;
  assign w_is_digit  = (in_code <= CODE_W'(DIGIT_MAX));
  assign w_key_clr   = (in_code == CODE_W'(KEY_CLR));
  assign w_key_ent   = (in_code == CODE_W'(KEY_ENT));
  assign w_key_bsp   = (in_code == CODE_W'(KEY_BSP));
  assign w_tens      = (r_disp_l == LP_BLANK) ? '0 : r_disp_l;
  assign w_mul_start = w_accept & w_key_ent & ((r_state == ST_ONE) || (r_state == ST_TWO));

  lr_mul10_add #(
    .NUM_W  (NUM_W),
    .CODE_W (CODE_W)
  ) u_mul (
    .clk     (clk_50MHz),
    .rst     (reset),
    .i_start (w_mul_start),
    .i_tens  (w_tens),
    .i_ones  (r_disp_r),
    .o_done  (w_mul_done),
    .o_sum   (w_mul_sum)
  );

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          if (w_is_digit)     w_state_nxt = ST_ONE;
          else if (w_key_ent) w_state_nxt = ST_EMIT;
        end
      end
      ST_ONE: begin
        if (w_accept) begin
          if (w_is_digit)                  w_state_nxt = ST_TWO;
          else if (w_key_clr || w_key_bsp) w_state_nxt = ST_EMPTY;
          else if (w_key_ent)              w_state_nxt = ST_MUL;
        end
      end
      ST_TWO: begin
        if (w_accept) begin
          if (w_key_bsp)      w_state_nxt = ST_ONE;
          else if (w_key_clr) w_state_nxt = ST_EMPTY;
          else if (w_key_ent) w_state_nxt = ST_MUL;
        end
      end
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_EMIT;
      ST_EMIT: if (r_out_valid && out_ready) w_state_nxt = ST_EMPTY;
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_EMPTY, ST_ONE, ST_TWO: w_in_ready = 1'b1;
      default:                  w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_disp_l     <= LP_BLANK;
      r_disp_r     <= LP_BLANK;
      r_out_valid  <= 1'b0;
      r_out_number <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept && w_is_digit) begin
            r_disp_r <= in_code;
            r_disp_l <= LP_BLANK;
          end else if (w_accept && w_key_ent) begin
            r_out_number <= LP_BLANKN;
          end
        end
        ST_ONE: begin
          if (w_accept && w_is_digit) begin
            r_disp_l <= r_disp_r;
            r_disp_r <= in_code;
          end else if (w_accept && (w_key_clr || w_key_bsp)) begin
            r_disp_l <= LP_BLANK;
            r_disp_r <= LP_BLANK;
          end
        end
        ST_TWO: begin
          if (w_accept && w_key_bsp) begin
            r_disp_r <= r_disp_l;
            r_disp_l <= LP_BLANK;
          end else if (w_accept && w_key_clr) begin
            r_disp_l <= LP_BLANK;
            r_disp_r <= LP_BLANK;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_out_number <= w_mul_sum;
            r_out_valid  <= 1'b1;
          end
        end
        ST_EMIT: begin
          // Blank-number entry reaches EMIT with valid still low; raise it one cycle later.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_disp_l    <= LP_BLANK;
            r_disp_r    <= LP_BLANK;
          end else if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_number = r_out_number;
  assign dispL      = r_disp_l;
  assign dispR      = r_disp_r;

endmodule
